radix2_divider: RTL

RADIX2_DIVIDER -- requirements
Module: radix2_divider

---
 rtl/radix2_div_pkg.sv | 13 +
 rtl/radix2_div_cu.sv | 83 ++++++++
 rtl/radix2_divider.sv | 92 +++++++++
 3 files changed

// File: rtl/radix2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM state encoding
// and the default operand width.
package radix2_div_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIVIDE
    } state_t;

endpackage

// File: rtl/radix2_div_cu.sv
// Control unit for radix2_divider: three-state FSM plus iteration counter.
// With RADIX2_DIV_ZERO_CHECK_EN defined, a zero divisor short-circuits LOAD back to IDLE.
module radix2_div_cu
    import radix2_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef RADIX2_DIV_ZERO_CHECK_EN
    input  logic divisor_zero,
`endif
    output logic load,
    output logic shift,
    output logic done,
    output logic busy,
    output logic ready
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter holds at the terminal value on the last step so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift && !done) begin
            count <= count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                state_next = DIVIDE;
`ifdef RADIX2_DIV_ZERO_CHECK_EN
                if (divisor_zero) begin
                    state_next = IDLE;
                end
`endif
            end
            DIVIDE: begin
                shift = 1'b1;
                if (count == LAST) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign ready = (state == IDLE);

endmodule

// File: rtl/radix2_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per DIVIDE cycle.
// Define RADIX2_DIV_ZERO_CHECK_EN to detect divisor==0 and finish early with div_by_zero set.
module radix2_divider
    import radix2_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             ready,
    output logic             div_by_zero
);

    logic             load;
    logic             shift;
    logic             done;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH:0]   r_shifted;
    logic [WIDTH:0]   trial;

    // R is always below B, so the shifted partial remainder needs one extra bit.
    assign r_shifted = {r_reg, a_reg[WIDTH-1]};
    assign trial     = r_shifted - {1'b0, b_reg};

    radix2_div_cu #(
        .WIDTH(WIDTH)
    ) u_cu (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef RADIX2_DIV_ZERO_CHECK_EN
        .divisor_zero(divisor == '0),
`endif
        .load        (load),
        .shift       (shift),
        .done        (done),
        .busy        (busy),
        .ready       (ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
        end else if (load) begin
            b_reg <= divisor;
`ifdef RADIX2_DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
                a_reg <= '1;
                r_reg <= dividend;
            end else begin
                a_reg <= dividend;
                r_reg <= '0;
            end
`else
            a_reg <= dividend;
            r_reg <= '0;
`endif
        end else if (shift) begin
            r_reg <= trial[WIDTH] ? r_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            a_reg <= {a_reg[WIDTH-2:0], ~trial[WIDTH]};
        end
    end

`ifdef RADIX2_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_by_zero <= 1'b0;
        end else if (load) begin
            div_by_zero <= (divisor == '0);
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

    assign quotient  = a_reg;
    assign remainder = r_reg;

    // The terminal step is always a DIVIDE step.
    done_implies_shift: assert property (@(posedge clk) disable iff (!rst) done |-> shift);

endmodule
